// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word-addressed data RAM responder for lw/sw with latency, error pulse and counters
// Serves one request at a time: capture in IDLE, wait LATENCY cycles, pulse MemReady (with MemError on bad requests).
module data_memory_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemError,
   output logic [15:0] RdCount,
   output logic [15:0] WrCount,
   output logic [15:0] ErrCount
);
   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN_MASK = 32'(DEPTH_WORDS * 4 - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t state, state_next;

   logic [31:0]   ram [DEPTH_WORDS];
   logic          op_rd, op_wr;
   logic [31:0]   op_addr, op_wdata;
   logic [3:0]    cnt;
   logic          err_q;
   logic [31:0]   rdata_q;
   logic [15:0]   rd_cnt, wr_cnt, err_cnt;

   logic          capture, enter_done;
   logic          acc_rd, acc_wr, acc_err;
   logic [31:0]   acc_addr, acc_wdata;
   logic [AW-1:0] acc_idx;

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      enter_done = 1'b0;
      case (state)
         IDLE: begin
            if (MemRead | MemWrite) begin
               capture = 1'b1;
               if (LATENCY == 0) begin
                  state_next = DONE;
                  enter_done = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_next = DONE;
               enter_done = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // With LATENCY=0 the access completes on its capture edge, so it must be judged on the live inputs.
   always_comb begin
      acc_rd    = op_rd;
      acc_wr    = op_wr;
      acc_addr  = op_addr;
      acc_wdata = op_wdata;
      if (state == IDLE) begin
         acc_rd    = MemRead;
         acc_wr    = MemWrite;
         acc_addr  = Address;
         acc_wdata = WriteData;
      end
   end

   assign acc_idx = acc_addr[AW+1:2];
   assign acc_err = (acc_rd & acc_wr) | (acc_addr[1:0] != 2'b00) |
                    ((acc_addr & ~SPAN_MASK) != BASE_ADDR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_rd    <= 1'b0;
         op_wr    <= 1'b0;
         op_addr  <= 32'd0;
         op_wdata <= 32'd0;
         cnt      <= 4'd0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
         rd_cnt   <= 16'd0;
         wr_cnt   <= 16'd0;
         err_cnt  <= 16'd0;
      end else begin
         state <= state_next;
         if (capture) begin
            op_rd    <= MemRead;
            op_wr    <= MemWrite;
            op_addr  <= Address;
            op_wdata <= WriteData;
            cnt      <= 4'(LATENCY - 1);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_done) begin
            err_q <= acc_err;
            if (acc_err) begin
               rdata_q <= 32'd0;
               if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else if (acc_rd) begin
               rdata_q <= ram[acc_idx];
               if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end else if (acc_wr) begin
               if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && enter_done && !acc_err && acc_wr) ram[acc_idx] <= acc_wdata;
   end

   assign MemReady = (state == DONE);
   assign MemError = (state == DONE) & err_q;
   assign ReadData = rdata_q;
   assign RdCount  = rd_cnt;
   assign WrCount  = wr_cnt;
   assign ErrCount = err_cnt;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed and randomized check of data_memory_responder against a timeline model
// Instance 0 runs LATENCY=2, instance 1 runs LATENCY=0; both share one clock.
module tb_data_memory_responder;
   localparam int          DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s  [2];
   logic        rd_req [2];
   logic        wr_req [2];
   logic [31:0] addr   [2];
   logic [31:0] wdata  [2];
   logic [31:0] rdata  [2];
   logic        ready  [2];
   logic        err    [2];
   logic [15:0] rdc    [2];
   logic [15:0] wrc    [2];
   logic [15:0] erc    [2];

   data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_lat2 (
      .clk(clk), .rst(rst_s[0]), .MemRead(rd_req[0]), .MemWrite(wr_req[0]), .Address(addr[0]),
      .WriteData(wdata[0]), .ReadData(rdata[0]), .MemReady(ready[0]), .MemError(err[0]),
      .RdCount(rdc[0]), .WrCount(wrc[0]), .ErrCount(erc[0]));

   data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)) u_lat0 (
      .clk(clk), .rst(rst_s[1]), .MemRead(rd_req[1]), .MemWrite(wr_req[1]), .Address(addr[1]),
      .WriteData(wdata[1]), .ReadData(rdata[1]), .MemReady(ready[1]), .MemError(err[1]),
      .RdCount(rdc[1]), .WrCount(wrc[1]), .ErrCount(erc[1]));

   int     tests_run    = 0;
   int     tests_failed = 0;
   longint cyc          = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Model: an accepted request completes LATENCY+1 cycles later; its effects are visible from that cycle on.
   logic [31:0] m_mem    [2][DEPTH];
   bit          m_known  [2][DEPTH];
   bit          m_valid  [2];
   bit          m_busy   [2];
   longint      m_done   [2];
   bit          m_err    [2];
   bit          m_rd     [2];
   logic [31:0] m_addr   [2];
   logic [31:0] m_wdata  [2];
   logic [31:0] m_rdata  [2];
   bit          m_rknown [2];
   int unsigned m_rdc    [2];
   int unsigned m_wrc    [2];
   int unsigned m_erc    [2];

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic bit in_range(input logic [31:0] a);
      return (a - BASE) < 32'(4 * DEPTH);
   endfunction

   function automatic int unsigned sat(input int unsigned v);
      return (v >= 32'd65535) ? 32'd65535 : v + 32'd1;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit exp_ready;
         int idx;
         if (m_valid[k]) begin
            exp_ready = m_busy[k] && (cyc == m_done[k]);
            tests_run++;
            if (ready[k] !== exp_ready || err[k] !== (exp_ready && m_err[k])) begin
               tests_failed++;
               $display("FAIL handshake inst%0d cyc%0d: MemReady=%b MemError=%b, required %b %b",
                        k, cyc, ready[k], err[k], exp_ready, exp_ready && m_err[k]);
            end
            if (m_rknown[k]) begin
               tests_run++;
               if (rdata[k] !== m_rdata[k]) begin
                  tests_failed++;
                  $display("FAIL read_data inst%0d cyc%0d: got %h, required %h", k, cyc, rdata[k], m_rdata[k]);
               end
            end
            tests_run++;
            if ({rdc[k], wrc[k], erc[k]} !== {16'(m_rdc[k]), 16'(m_wrc[k]), 16'(m_erc[k])}) begin
               tests_failed++;
               $display("FAIL counters inst%0d cyc%0d: rd/wr/err=%h/%h/%h, required %h/%h/%h", k, cyc,
                        rdc[k], wrc[k], erc[k], 16'(m_rdc[k]), 16'(m_wrc[k]), 16'(m_erc[k]));
            end
         end
         if (rst_s[k]) begin
            m_valid[k]  = 1'b1;
            m_busy[k]   = 1'b0;
            m_rdc[k]    = 0;
            m_wrc[k]    = 0;
            m_erc[k]    = 0;
            m_rdata[k]  = 32'd0;
            m_rknown[k] = 1'b1;
         end else if (m_valid[k]) begin
            if (m_busy[k] && cyc == m_done[k]) begin
               m_busy[k] = 1'b0;
            end else if (!m_busy[k] && (rd_req[k] || wr_req[k])) begin
               m_busy[k]  = 1'b1;
               m_done[k]  = cyc + lat_of(k) + 1;
               m_rd[k]    = rd_req[k];
               m_addr[k]  = addr[k];
               m_wdata[k] = wdata[k];
               m_err[k]   = (rd_req[k] && wr_req[k]) || (addr[k][1:0] != 2'b00) || !in_range(addr[k]);
            end
            if (m_busy[k] && cyc == m_done[k] - 1) begin
               if (m_err[k]) begin
                  m_erc[k]    = sat(m_erc[k]);
                  m_rdata[k]  = 32'd0;
                  m_rknown[k] = 1'b1;
               end else if (m_rd[k]) begin
                  idx         = int'((m_addr[k] - BASE) >> 2);
                  m_rdc[k]    = sat(m_rdc[k]);
                  m_rdata[k]  = m_mem[k][idx];
                  m_rknown[k] = m_known[k][idx];
               end else begin
                  idx             = int'((m_addr[k] - BASE) >> 2);
                  m_wrc[k]        = sat(m_wrc[k]);
                  m_mem[k][idx]   = m_wdata[k];
                  m_known[k][idx] = 1'b1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int k);
      rst_s[k]  = 1'b1;
      rd_req[k] = 1'b0;
      wr_req[k] = 1'b0;
      step();
      step();
      rst_s[k] = 1'b0;
   endtask

   // Present a request in the current cycle and wait for MemReady; lat counts cycles after the request.
   task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input bit hold, input bit scramble,
                         output int lat, output logic [31:0] rd_o, output logic e_o);
      int n;
      n    = 0;
      lat  = -1;
      rd_o = 32'd0;
      e_o  = 1'b0;
      rd_req[k] = rd;
      wr_req[k] = wr;
      addr[k]   = a;
      wdata[k]  = d;
      while (lat < 0) begin
         step();
         n++;
         if (ready[k] === 1'b1) begin
            lat  = n;
            rd_o = rdata[k];
            e_o  = err[k];
         end else if (n > 40) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout inst%0d: no MemReady after %0d cycles, required after %0d", k, n, lat_of(k) + 1);
            lat = n;
         end else if (scramble) begin
            addr[k]  = $urandom;
            wdata[k] = $urandom;
         end
      end
      if (!hold) begin
         step();
         rd_req[k] = 1'b0;
         wr_req[k] = 1'b0;
      end
   endtask

   int          lat;
   logic [31:0] rv;
   logic        ev;

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst_s[k]  = 1'b1;
         rd_req[k] = 1'b0;
         wr_req[k] = 1'b0;
         addr[k]   = 32'd0;
         wdata[k]  = 32'd0;
      end
      repeat (3) step();
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      chk("reset_ready", {31'd0, ready[0]}, 32'd0);
      chk("reset_error", {31'd0, err[0]}, 32'd0);
      chk("reset_rdata", rdata[0], 32'd0);
      chk("reset_counts", {rdc[0], wrc[1]}, 32'd0);
      chk("reset_errcount", {erc[0], erc[1]}, 32'd0);

      access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, lat, rv, ev);
      chk("t1_sw_latency", 32'(lat), 32'd3);
      chk("t1_sw_error", {31'd0, ev}, 32'd0);
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, lat, rv, ev);
      chk("t1_lw_latency", 32'(lat), 32'd3);
      chk("t1_lw_data", rv, 32'hDEAD_BEEF);
      chk("t1_counts", {rdc[0], wrc[0]}, {16'd1, 16'd1});

      access(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0, 1'b0, lat, rv, ev);
      chk("t3_misaligned_err", {31'd0, ev}, 32'd1);
      chk("t3_misaligned_data", rv, 32'd0);
      access(0, 1'b0, 1'b1, 32'h400, 32'h5555_AAAA, 1'b0, 1'b0, lat, rv, ev);
      chk("t3_range_err", {31'd0, ev}, 32'd1);
      chk("t3_counts", {erc[0], rdc[0]}, {16'd2, 16'd1});
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, lat, rv, ev);
      chk("t3_ram_unchanged", rv, 32'hDEAD_BEEF);

      access(0, 1'b0, 1'b1, 32'h8, 32'h0BAD_F00D, 1'b0, 1'b0, lat, rv, ev);
      do_reset(0);
      access(0, 1'b1, 1'b1, 32'h8, 32'h1234_0000, 1'b0, 1'b0, lat, rv, ev);
      chk("t4_conflict_err", {31'd0, ev}, 32'd1);
      chk("t4_counts", {erc[0], rdc[0], wrc[0]}, {16'd1, 16'd0, 16'd0});
      access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, lat, rv, ev);
      chk("t4_ram_unchanged", rv, 32'h0BAD_F00D);

      access(0, 1'b0, 1'b1, 32'h20, 32'h1111_1111, 1'b0, 1'b0, lat, rv, ev);
      do_reset(0);
      wr_req[0] = 1'b1;
      addr[0]   = 32'h20;
      wdata[0]  = 32'h2222_2222;
      step();
      rst_s[0] = 1'b1;
      step();
      rst_s[0]  = 1'b0;
      wr_req[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t5_no_ready", {31'd0, ready[0]}, 32'd0);
         step();
      end
      chk("t5_counts", {rdc[0], wrc[0]}, 32'd0);
      access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, lat, rv, ev);
      chk("t5_old_data", rv, 32'h1111_1111);

      access(1, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, 1'b0, lat, rv, ev);
      chk("t2_sw_latency", 32'(lat), 32'd1);
      access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, lat, rv, ev);
      chk("t2_lw_latency", 32'(lat), 32'd1);
      chk("t2_lw_data", rv, 32'h1234_5678);

      do_reset(1);
      force u_lat0.rd_cnt = 16'hFFFC;
      m_rdc[1] = 32'hFFFC;
      #1;
      release u_lat0.rd_cnt;
      step();
      for (int i = 0; i < 2; i++) access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, lat, rv, ev);
      chk("t6_rdcount_fffe", {16'd0, rdc[1]}, 32'h0000_FFFE);
      for (int i = 0; i < 3; i++) access(1, 1'b1, 1'b0, 32'h0, 32'h0, (i < 2), 1'b0, lat, rv, ev);
      chk("t6_rdcount_sat", {16'd0, rdc[1]}, 32'h0000_FFFF);
      chk("t6_read_data", rv, 32'h1234_5678);

      for (int k = 0; k < 2; k++) begin
         do_reset(k);
         for (int w = 0; w < 16; w++)
            access(k, 1'b0, 1'b1, BASE + 32'(w * 4), $urandom, 1'b0, 1'b0, lat, rv, ev);
         for (int t = 0; t < 150; t++) begin
            int          r;
            bit          rd, wr, hold;
            logic [31:0] a;
            r  = int'($urandom_range(0, 99));
            a  = BASE + 32'($urandom_range(0, 15) << 2);
            rd = 1'b0;
            wr = 1'b0;
            if (r < 45) rd = 1'b1;
            else if (r < 85) wr = 1'b1;
            else if (r < 90) begin rd = 1'b1; wr = 1'b1; end
            else begin
               rd = $urandom_range(0, 1) == 1;
               wr = !rd;
               if (r < 95) a = a | 32'($urandom_range(1, 3));
               else a = BASE + 32'h400 + 32'($urandom_range(0, 255) << 2);
            end
            hold = ($urandom_range(0, 3) == 0);
            access(k, rd, wr, a, $urandom, hold, 1'b1, lat, rv, ev);
            if (!hold) repeat ($urandom_range(0, 2)) step();
         end
         rd_req[k] = 1'b0;
         wr_req[k] = 1'b0;
         repeat (3) step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
